// File: rtl/pa_isa_pkg.sv
// Shared definitions for the dual-issue scheduler: field widths, queue-entry layout
// and scheduler states.
package pa_isa_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned OPR_W   = 16;
  localparam int unsigned ENTRY_W = 2 + OPC_W + REG_W + OPR_W;

  // Entry layout, MSB first: {is_branch, format, opcode, reg, operand}
  localparam int unsigned OPR_LSB = 0;
  localparam int unsigned REG_LSB = OPR_LSB + OPR_W;
  localparam int unsigned OPC_LSB = REG_LSB + REG_W;
  localparam int unsigned FMT_BIT = OPC_LSB + OPC_W;
  localparam int unsigned BR_BIT  = FMT_BIT + 1;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StWaitBr = 1'b1
  } sched_state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic             is_br,
                                                    input logic             fmt,
                                                    input logic [OPC_W-1:0] opc,
                                                    input logic [REG_W-1:0] rd,
                                                    input logic [OPR_W-1:0] opr);
    return {is_br, fmt, opc, rd, opr};
  endfunction

endpackage

// File: rtl/sched_queue.sv
// Circular instruction buffer with two write ports at the tail and two read ports at the head.
// Pointers carry one extra MSB so a full queue is distinguishable from an empty one.
module sched_queue
  import pa_isa_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [1:0]             push_cnt,
  input  logic [1:0]             pop_cnt,
  input  logic [ENTRY_W-1:0]     wdata0,
  input  logic [ENTRY_W-1:0]     wdata1,
  output logic [ENTRY_W-1:0]     head_entry,
  output logic [ENTRY_W-1:0]     head1_entry,
  output logic [$clog2(Depth):0] count,
  output logic                   full
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = (AddrW + 1)'(1);

  logic [ENTRY_W-1:0] mem [Depth];
  logic [AddrW:0]     head_q, tail_q, head1_ptr, tail1_ptr;

  assign head1_ptr   = head_q + PtrOne;
  assign tail1_ptr   = tail_q + PtrOne;
  assign count       = tail_q - head_q;
  assign full        = (count == (AddrW + 1)'(Depth));
  assign head_entry  = mem[head_q[AddrW-1:0]];
  assign head1_entry = mem[head1_ptr[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[tail_q[AddrW-1:0]] <= wdata0;
    if (push_cnt == 2'd2) mem[tail1_ptr[AddrW-1:0]] <= wdata1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      head_q <= tail_q;
    end else begin
      head_q <= head_q + {{(AddrW - 1){1'b0}}, pop_cnt};
      tail_q <= tail_q + {{(AddrW - 1){1'b0}}, push_cnt};
    end
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Two-wide in-order issue stage: queues parsed instruction pairs, pairs independent ALU ops
// onto port 1, and holds issue while a branch on port 0 is unresolved.
module dual_issue_scheduler
  import pa_isa_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned SKID        = 6
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               enable_i1,
  input  logic               enable_i2,
  input  logic               isBranch_i1,
  input  logic               isBranch_i2,
  input  logic               format_i1,
  input  logic               format_i2,
  input  logic [OPC_W-1:0]   opcode_i1,
  input  logic [OPC_W-1:0]   opcode_i2,
  input  logic [REG_W-1:0]   reg_i1,
  input  logic [REG_W-1:0]   reg_i2,
  input  logic [OPR_W-1:0]   operand_i1,
  input  logic [OPR_W-1:0]   operand_i2,
  output logic               stall_o,
  input  logic               exec_ready_i,
  output logic               issue_valid_o0,
  output logic               issue_valid_o1,
  output logic [ENTRY_W-1:0] issue_instr_o0,
  output logic [ENTRY_W-1:0] issue_instr_o1,
  input  logic               br_resolve_i,
  input  logic               br_taken_i,
  output logic               overflow_o
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned CntW = PtrW + 1;

  sched_state_e       state_q;
  logic [ENTRY_W-1:0] slot1, slot2, wdata0, head_entry, head1_entry;
  logic [PtrW-1:0]    count;
  logic               q_full;
  logic [1:0]         n_req, push_cnt, pop_cnt;
  logic [CntW-1:0]    free, count_next;
  logic               can_issue, dual_ok, flush, drop, stall_d;
  logic               stall_q, overflow_q, valid0_q, valid1_q;
  logic [ENTRY_W-1:0] instr0_q, instr1_q;

  assign slot1  = pack_entry(isBranch_i1, format_i1, opcode_i1, reg_i1, operand_i1);
  assign slot2  = pack_entry(isBranch_i2, format_i2, opcode_i2, reg_i2, operand_i2);
  // A lone slot-2 instruction takes the first free tail position.
  assign wdata0 = enable_i1 ? slot1 : slot2;
  assign n_req  = {1'b0, enable_i1} + {1'b0, enable_i2};

  // Port 1 takes head+1 only if neither is a branch and it neither rewrites nor reads head.reg.
  assign dual_ok = (count > PtrW'(1)) && !head_entry[BR_BIT] && !head1_entry[BR_BIT] &&
                   (head1_entry[REG_LSB +: REG_W] != head_entry[REG_LSB +: REG_W]) &&
                   !(!head1_entry[FMT_BIT] &&
                     (head1_entry[OPR_LSB +: REG_W] == head_entry[REG_LSB +: REG_W]));

  assign can_issue = (state_q == StRun) && exec_ready_i && (count != '0);
  assign pop_cnt   = !can_issue ? 2'd0 : (dual_ok ? 2'd2 : 2'd1);
  assign flush     = (state_q == StWaitBr) && br_resolve_i && br_taken_i;

  always_comb begin
    // Entries popped this cycle are free for this cycle's pushes.
    free     = (q_full ? '0 : (CntW'(QUEUE_DEPTH) - {1'b0, count})) +
               {{(CntW - 2){1'b0}}, pop_cnt};
    push_cnt = n_req;
    drop     = 1'b0;
    if (flush) begin
      push_cnt = 2'd0;
    end else if ({{(CntW - 2){1'b0}}, n_req} > free) begin
      push_cnt = free[1:0];
      drop     = 1'b1;
    end
    count_next = flush ? '0 : ({1'b0, count} + {{(CntW - 2){1'b0}}, push_cnt} -
                               {{(CntW - 2){1'b0}}, pop_cnt});
    stall_d    = (count_next > CntW'(QUEUE_DEPTH - SKID));
  end

  sched_queue #(
    .Depth(QUEUE_DEPTH)
  ) u_queue (
    .clk        (clock_i),
    .rst_n      (reset_ni),
    .flush      (flush),
    .push_cnt   (push_cnt),
    .pop_cnt    (pop_cnt),
    .wdata0     (wdata0),
    .wdata1     (slot2),
    .head_entry (head_entry),
    .head1_entry(head1_entry),
    .count      (count),
    .full       (q_full)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StRun;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      instr0_q   <= '0;
      instr1_q   <= '0;
    end else begin
      stall_q  <= stall_d;
      valid0_q <= (pop_cnt != 2'd0);
      valid1_q <= (pop_cnt == 2'd2);
      if (drop) overflow_q <= 1'b1;
      if (pop_cnt != 2'd0) instr0_q <= head_entry;
      if (pop_cnt == 2'd2) instr1_q <= head1_entry;
      unique case (state_q)
        StRun:    if ((pop_cnt != 2'd0) && head_entry[BR_BIT]) state_q <= StWaitBr;
        StWaitBr: if (br_resolve_i) state_q <= StRun;
        default:  state_q <= StRun;
      endcase
    end
  end

  assign stall_o        = stall_q;
  assign overflow_o     = overflow_q;
  assign issue_valid_o0 = valid0_q;
  assign issue_valid_o1 = valid1_q;
  assign issue_instr_o0 = instr0_q;
  assign issue_instr_o1 = instr1_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed and randomized bench for dual_issue_scheduler against a queue-level reference model.
module tb_dual_issue_scheduler;

  localparam int DEPTH = 16;
  localparam int SKID  = 6;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        en1 = 0, en2 = 0, br1 = 0, br2 = 0, f1 = 0, f2 = 0;
  logic [6:0]  op1 = '0, op2 = '0;
  logic [4:0]  r1 = '0, r2 = '0;
  logic [15:0] o1 = '0, o2 = '0;
  logic        exec_ready = 0, br_resolve = 0, br_taken = 0;
  logic        stall_o, issue_valid_o0, issue_valid_o1, overflow_o;
  logic [29:0] issue_instr_o0, issue_instr_o1;

  dual_issue_scheduler #(
    .QUEUE_DEPTH(DEPTH),
    .SKID       (SKID)
  ) dut (
    .clock_i       (clock_i),
    .reset_ni      (reset_ni),
    .enable_i1     (en1),
    .enable_i2     (en2),
    .isBranch_i1   (br1),
    .isBranch_i2   (br2),
    .format_i1     (f1),
    .format_i2     (f2),
    .opcode_i1     (op1),
    .opcode_i2     (op2),
    .reg_i1        (r1),
    .reg_i2        (r2),
    .operand_i1    (o1),
    .operand_i2    (o2),
    .stall_o       (stall_o),
    .exec_ready_i  (exec_ready),
    .issue_valid_o0(issue_valid_o0),
    .issue_valid_o1(issue_valid_o1),
    .issue_instr_o0(issue_instr_o0),
    .issue_instr_o1(issue_instr_o1),
    .br_resolve_i  (br_resolve),
    .br_taken_i    (br_taken),
    .overflow_o    (overflow_o)
  );

  always #5 clock_i = ~clock_i;

  int n_chk = 0, n_err = 0;
  int issued_cnt = 0;
  bit counting = 0;

  // Reference model: instruction queue plus "waiting on branch" flag and expected outputs.
  logic [29:0] mq[$];
  bit          m_wait, m_ovf, e_v0, e_v1, e_stall;
  logic [29:0] e_i0, e_i1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wait = 0; m_ovf = 0; e_v0 = 0; e_v1 = 0; e_stall = 0;
    e_i0 = '0; e_i1 = '0;
  endtask

  task automatic model_push(input logic [29:0] e);
    if (mq.size() < DEPTH) mq.push_back(e);
    else m_ovf = 1;
  endtask

  task automatic model_step();
    logic [29:0] h0, h1;
    bit          pair, flushed;
    e_v0 = 0; e_v1 = 0; flushed = 0;
    if (!m_wait) begin
      if (exec_ready && mq.size() > 0) begin
        h0 = mq.pop_front();
        e_v0 = 1; e_i0 = h0;
        pair = 0;
        if (mq.size() > 0) begin
          h1 = mq[0];
          pair = !h0[29] && !h1[29] && (h1[20:16] != h0[20:16]) &&
                 !(!h1[28] && (h1[4:0] == h0[20:16]));
        end
        if (pair) begin
          h1 = mq.pop_front();
          e_v1 = 1; e_i1 = h1;
        end
        if (h0[29]) m_wait = 1;
      end
    end else if (br_resolve) begin
      if (br_taken) begin
        mq.delete();
        flushed = 1;
      end
      m_wait = 0;
    end
    if (!flushed) begin
      if (en1) model_push({br1, f1, op1, r1, o1});
      if (en2) model_push({br2, f2, op2, r2, o2});
    end
    e_stall = (mq.size() > DEPTH - SKID);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid0"}, {31'b0, issue_valid_o0}, {31'b0, e_v0});
    chk({tag, ".valid1"}, {31'b0, issue_valid_o1}, {31'b0, e_v1});
    chk({tag, ".instr0"}, {2'b0, issue_instr_o0}, {2'b0, e_i0});
    chk({tag, ".instr1"}, {2'b0, issue_instr_o1}, {2'b0, e_i1});
    chk({tag, ".stall"}, {31'b0, stall_o}, {31'b0, e_stall});
    chk({tag, ".overflow"}, {31'b0, overflow_o}, {31'b0, m_ovf});
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clock_i);
    #1;
    check_all(tag);
    if (counting) issued_cnt += int'(issue_valid_o0) + int'(issue_valid_o1);
  endtask

  task automatic set1(input logic b, input logic f, input logic [6:0] op, input logic [4:0] r,
                      input logic [15:0] o);
    en1 = 1; br1 = b; f1 = f; op1 = op; r1 = r; o1 = o;
  endtask

  task automatic set2(input logic b, input logic f, input logic [6:0] op, input logic [4:0] r,
                      input logic [15:0] o);
    en2 = 1; br2 = b; f2 = f; op2 = op; r2 = r; o2 = o;
  endtask

  task automatic clr();
    en1 = 0; en2 = 0; br_resolve = 0; br_taken = 0;
  endtask

  task automatic rnd1(input bit allow_br);
    set1(allow_br && ($urandom_range(0, 7) == 0), 1'($urandom), 7'($urandom),
         5'($urandom_range(0, 7)), {11'($urandom), 5'($urandom_range(0, 7))});
  endtask

  task automatic rnd2(input bit allow_br);
    set2(allow_br && ($urandom_range(0, 7) == 0), 1'($urandom), 7'($urandom),
         5'($urandom_range(0, 7)), {11'($urandom), 5'($urandom_range(0, 7))});
  endtask

  task automatic drain(input string tag);
    for (int g = 0; g < 300 && (mq.size() > 0 || m_wait); g++) begin
      clr();
      exec_ready = 1;
      br_resolve = m_wait;
      step(tag);
    end
    clr();
    step({tag, "_idle"});
    chk({tag, "_empty"}, {31'b0, issue_valid_o0}, 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    reset_ni = 1;

    // Basic pair: independent ALU ops issue together.
    exec_ready = 1;
    set1(0, 1, 7'h01, 5'd3, 16'h1234);
    set2(0, 0, 7'h02, 5'd4, 16'd5);
    step("pair_push");
    clr();
    step("pair_issue");
    chk("pair_p0_reg", {27'b0, issue_instr_o0[20:16]}, 32'd3);
    chk("pair_p0_opr", {16'b0, issue_instr_o0[15:0]}, 32'h1234);
    chk("pair_p1_valid", {31'b0, issue_valid_o1}, 32'd1);
    chk("pair_p1_reg", {27'b0, issue_instr_o1[20:16]}, 32'd4);

    // RAW through the register operand serialises.
    set1(0, 1, 7'h03, 5'd7, 16'h0042);
    set2(0, 0, 7'h04, 5'd8, 16'd7);
    step("raw_push");
    clr();
    step("raw_first");
    chk("raw_p1_blocked", {31'b0, issue_valid_o1}, 32'd0);
    step("raw_second");
    chk("raw_second_reg", {27'b0, issue_instr_o0[20:16]}, 32'd8);

    // Branch, then taken resolve flushes everything queued behind it.
    for (int rep = 0; rep < 2; rep++) begin
      set1(1, 1, 7'h10, 5'd1, 16'h0100);
      set2(0, 1, 7'h11, 5'd2, 16'h0200);
      step("br_push");
      clr();
      step("br_issue");
      chk("br_p0_only", {30'b0, issue_valid_o0, issue_valid_o1}, 32'd2);
      for (int b = 0; b < 3; b++) begin
        rnd1(0);
        rnd2(0);
        step("br_wait");
        chk("br_wait_noissue", {31'b0, issue_valid_o0}, 32'd0);
      end
      clr();
      br_resolve = 1;
      br_taken = (rep == 0);
      rnd1(0);
      step("br_resolve");
      clr();
      for (int k = 0; k < 3; k++) step(rep == 0 ? "br_flushed" : "br_resume");
      if (rep == 0) chk("flush_noissue", {31'b0, issue_valid_o0}, 32'd0);
      drain("br_drain");
    end

    // Backpressure: stall once count exceeds DEPTH-SKID, overflow beyond DEPTH.
    exec_ready = 0;
    for (int c = 1; c <= 10; c++) begin
      rnd1(0);
      rnd2(0);
      step("bp_push");
      if (c == 5) chk("bp_stall_lo", {31'b0, stall_o}, 32'd0);
      if (c == 6) chk("bp_stall_hi", {31'b0, stall_o}, 32'd1);
      if (c == 8) chk("bp_no_ovf", {31'b0, overflow_o}, 32'd0);
    end
    chk("bp_ovf", {31'b0, overflow_o}, 32'd1);
    drain("bp_drain");

    // Wrap-around: 40 single pushes, random readiness, no loss.
    counting = 1;
    for (int w = 0; w < 40; w++) begin
      clr();
      if ($urandom_range(0, 1) == 1) rnd1(0);
      else rnd2(0);
      exec_ready = ($urandom_range(0, 3) != 0);
      step("wrap");
    end
    drain("wrap_drain");
    counting = 0;
    chk("wrap_count", issued_cnt, 32'd40);

    // Fully random traffic including branches and spurious resolves.
    for (int i = 0; i < 150; i++) begin
      clr();
      if ($urandom_range(0, 1) == 1) rnd1(1);
      if ($urandom_range(0, 1) == 1) rnd2(1);
      exec_ready = ($urandom_range(0, 3) != 0);
      br_resolve = ($urandom_range(0, 3) == 0);
      br_taken = 1'($urandom);
      step("rand");
    end
    drain("rand_drain");

    // Mid-operation reset while waiting on a branch with 5 entries queued.
    set1(1, 1, 7'h20, 5'd9, 16'h0009);
    set2(0, 1, 7'h21, 5'd10, 16'h000a);
    step("mr_push");
    clr();
    step("mr_branch");
    for (int b = 0; b < 2; b++) begin
      rnd1(0);
      rnd2(0);
      step("mr_fill");
    end
    clr();
    #2;
    reset_ni = 0;
    #1;
    model_reset();
    check_all("mr_async");
    #2;
    reset_ni = 1;
    set1(0, 1, 7'h30, 5'd11, 16'h0bad);
    set2(0, 1, 7'h31, 5'd12, 16'h0cab);
    exec_ready = 1;
    step("mr_push2");
    clr();
    step("mr_issue");
    chk("mr_pair", {30'b0, issue_valid_o0, issue_valid_o1}, 32'd3);
    chk("mr_p0_opr", {16'b0, issue_instr_o0[15:0]}, 32'h0bad);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
